// File: rtl/vedic_seq_mul.sv
// Sequential unsigned multiplier built around one 2x2 Vedic (Urdhva) core.
// One partial product per cycle, D*D cycles per multiply, valid/ready handshakes.

module vedic_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   logic c1;
   logic hi;

   assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
   assign hi   = a[1] & b[1];
   assign p[0] = a[0] & b[0];
   assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
   assign p[2] = hi ^ c1;
   assign p[3] = hi & c1;
endmodule

// state | meaning
// IDLE  | waiting for an operand pair (in_ready high once out of reset)
// CALC  | accumulating one 2x2 partial product per cycle (busy high)
// DONE  | y holds the product, out_valid high until out_ready
module vedic_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] y,
   output logic               busy
);
   localparam int D  = WIDTH / 2;
   localparam int IW = (D > 1) ? $clog2(D) : 1;
   localparam logic [IW-1:0] LAST = IW'(D - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_nx;
   logic               in_ready_q;
   logic               accept;
   logic               last;
   logic [WIDTH-1:0]   a_reg, b_reg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] pp;
   logic [2*WIDTH-1:0] acc_sum;
   logic [IW-1:0]      i, j;
   logic [IW:0]        sum_ij;
   logic [3:0]         core_p;

   vedic_2x2 u_core (
      .a (a_reg[2*i +: 2]),
      .b (b_reg[2*j +: 2]),
      .p (core_p)
   );

   assign sum_ij  = {1'b0, i} + {1'b0, j};
   assign pp      = {{(2*WIDTH-4){1'b0}}, core_p} << {sum_ij, 1'b0};
   assign acc_sum = acc + pp;
   assign last    = (i == LAST) && (j == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready_q <= 1'b0;
      end else begin
         state      <= state_nx;
         in_ready_q <= (state_nx == IDLE);
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            // in_ready_q gates acceptance so nothing is taken during the reset-release cycle
            if (in_ready_q && in_valid) begin
               accept   = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         y     <= '0;
         i     <= '0;
         j     <= '0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
      end else if (state == CALC) begin
         acc <= acc_sum;
         if (last) y <= acc_sum;
         if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
         end else begin
            j <= j + 1'b1;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = (state == CALC);
   assign out_valid = (state == DONE);
endmodule

// File: tb/tb_vedic_seq_mul.sv
// Directed and randomized checks for vedic_seq_mul at WIDTH=8.

module tb_vedic_seq_mul;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic        busy;

   int checks;
   int errors;

   vedic_seq_mul #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One full transaction; hold = cycles out_ready stays low in DONE,
   // bp = during that hold keep in_valid high and scramble a/b.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2,
                         input int hold, input bit bp);
      int          n;
      int          edges;
      int          busy_cnt;
      logic [15:0] exp;
      logic [15:0] y_done;
      exp = 16'(ta) * 16'(tb2);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      a = ta;
      b = tb2;
      @(negedge clk);
      in_valid = 1'b0;
      a = ~ta;
      b = ~tb2;
      edges = 1;
      busy_cnt = 0;
      while (!out_valid && edges < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         a = 8'($urandom);
         in_valid = 1'($urandom);
         edges++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(edges), 32'd17);
      chk("busy_cycles", 32'(busy_cnt), 32'd16);
      chk("product", 32'(y), 32'(exp));
      y_done = y;
      for (int k = 0; k < hold; k++) begin
         if (bp) begin
            in_valid = 1'b1;
            a = 8'(k * 37 + 5);
            b = 8'(k * 11 + 3);
         end
         @(negedge clk);
         if (bp) begin
            chk("bp_y", 32'(y), 32'(y_done));
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (bp) begin
         chk("bp_no_accept", 32'(busy), 32'd0);
         chk("bp_idle_ready", 32'(in_ready), 32'd1);
         chk("y_kept", 32'(y), 32'(y_done));
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int saw_valid;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      run_op(8'd255, 8'd255, 0, 1'b0);
      run_op(8'd0, 8'd173, 0, 1'b0);
      run_op(8'd1, 8'd200, 0, 1'b0);
      run_op(8'd128, 8'd2, 0, 1'b0);
      run_op(8'd37, 8'd91, 5, 1'b1);

      // reset partway through CALC
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'd200;
      b = 8'd100;
      @(negedge clk);
      in_valid = 1'b0;
      saw_valid = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", 32'(y), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1;
      end
      chk("no_valid_after_rst", 32'(saw_valid), 32'd0);
      run_op(8'd12, 8'd13, 0, 1'b0);

      for (int t = 0; t < 1000; t++)
         run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vedic_seq_mul.md
VEDIC_SEQ_MUL -- requirements
Module: vedic_seq_mul

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; even, >= 4.
REQ-002 SHALL have derived constant D = WIDTH/2, the number of 2-bit digits per operand.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-009 SHALL have port out_valid  output  1  y holds a completed product.
REQ-010 SHALL have port out_ready  input  1  consumer accepts y.
REQ-011 SHALL have port y  output  2*WIDTH  unsigned product a*b.
REQ-012 SHALL have port busy  output  1  high while in CALC.

Function
REQ-013 SHALL instantiate one combinational 2x2 multiplier core (2-bit x 2-bit -> 4-bit) and reuse it every cycle; no full-width multiply operator.
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = 1 only in CALC.
REQ-016 SHALL, in IDLE with in_valid=1, on the clock edge: register a and b, clear the accumulator, set digit indices i=0, j=0, and go to CALC.
REQ-017 SHALL, in IDLE with in_valid=0, remain in IDLE.
REQ-018 SHALL, each CALC cycle, add pp(i,j) to the 2*WIDTH-bit accumulator, where pp(i,j) = core(a_reg[2i+1:2i], b_reg[2j+1:2j]) << 2*(i+j).
REQ-019 SHALL step the indices with j incrementing first; on j=D-1, j wraps to 0 and i increments.
REQ-020 SHALL, on the CALC cycle with i=D-1 and j=D-1, perform the final add, load y with the final sum, and go to DONE.
REQ-021 SHALL take exactly D*D CALC cycles (16 for WIDTH=8).
REQ-022 SHALL have fixed latency: out_valid rises D*D+1 edges after the accepting edge, with no early exit for zero operands.
REQ-023 SHALL size the accumulator at 2*WIDTH bits; the final result never overflows; intermediate sums are not truncated.
REQ-024 SHALL, in DONE, hold y and out_valid stable until out_ready=1.
REQ-025 SHALL, in DONE with out_ready=1, go to IDLE on that edge.
REQ-026 SHALL NOT accept a new operand in the same cycle as the DONE->IDLE transition (in_ready=0 in DONE).
REQ-027 SHALL ignore in_valid, a and b outside IDLE; changes to a/b during CALC SHALL NOT affect the result.
REQ-028 SHALL keep y holding the last product after leaving DONE, until the next result load.
REQ-029 SHALL register all outputs or decode them only from FSM state; no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, on rst_n=0 at any time: FSM=IDLE, accumulator=0, y=0, i=j=0, out_valid=0, busy=0, a_reg=b_reg=0.
REQ-031 SHALL hold in_ready=0 while rst_n=0 and in_ready=1 from the first cycle after release.
REQ-032 SHALL, on reset mid-CALC or in DONE, discard the operation with no out_valid pulse for it.

Verification
REQ-033 SHALL verify reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release in_ready=1.
REQ-034 SHALL verify max operands: a=255, b=255 (WIDTH=8) -> busy high 16 cycles; out_valid on edge 17 after accept; y=65025.
REQ-035 SHALL verify boundaries: a=0, b=173 -> y=0 after 17 edges; a=1, b=200 -> y=200; a=128, b=2 -> y=256.
REQ-036 SHALL verify backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> y, out_valid unchanged; in_ready=0; no new accept.
REQ-037 SHALL verify reset mid-operation: start 200*100, pull rst_n low at CALC cycle 7 -> no out_valid; then 12*13 -> y=156.
REQ-038 SHALL verify back-to-back traffic: 1000 random operand pairs with random out_ready -> each y equals a*b in order; latency always 17 edges from accept to out_valid.
